// File: rtl/cluster_word_serializer.sv
// Captures eight sorted clusters on a frame strobe and emits them as four two-cluster words.
// Also reports the valid-cluster count per frame and a saturating count of truncated frames.
module cluster_word_serializer #(
   parameter int unsigned          MXADRBITS  = 11,
   parameter int unsigned          MXCNTBITS  = 3,
   parameter int unsigned          MXVALIDADR = 1536,
   parameter logic [MXADRBITS-1:0] IDLE_ADR   = 11'h7FE
) (
   input  logic                               clock4x,
   input  logic                               reset,
   input  logic                               frame_valid,
   input  logic [MXADRBITS-1:0]               adr0_i,
   input  logic [MXADRBITS-1:0]               adr1_i,
   input  logic [MXADRBITS-1:0]               adr2_i,
   input  logic [MXADRBITS-1:0]               adr3_i,
   input  logic [MXADRBITS-1:0]               adr4_i,
   input  logic [MXADRBITS-1:0]               adr5_i,
   input  logic [MXADRBITS-1:0]               adr6_i,
   input  logic [MXADRBITS-1:0]               adr7_i,
   input  logic [MXCNTBITS-1:0]               cnt0_i,
   input  logic [MXCNTBITS-1:0]               cnt1_i,
   input  logic [MXCNTBITS-1:0]               cnt2_i,
   input  logic [MXCNTBITS-1:0]               cnt3_i,
   input  logic [MXCNTBITS-1:0]               cnt4_i,
   input  logic [MXCNTBITS-1:0]               cnt5_i,
   input  logic [MXCNTBITS-1:0]               cnt6_i,
   input  logic [MXCNTBITS-1:0]               cnt7_i,
   output logic [2*(MXADRBITS+MXCNTBITS)-1:0] dout,
   output logic                               dout_valid,
   output logic                               dout_first,
   output logic                               dout_last,
   output logic [3:0]                         cluster_cnt,
   output logic [7:0]                         overrun_cnt
);

   localparam int unsigned CluBits = MXADRBITS + MXCNTBITS;
   localparam logic [MXADRBITS:0] ValidAdr = (MXADRBITS + 1)'(MXVALIDADR);

   typedef logic [CluBits-1:0] clu_t;
   typedef enum logic [0:0] {StIdle, StSend} state_e;

   localparam clu_t IdleClu = {IDLE_ADR, {MXCNTBITS{1'b0}}};

   state_e               state_q;
   logic [1:0]           widx_q;
   clu_t                 cap_q [8];
   logic [MXADRBITS-1:0] in_adr [8];
   logic [MXCNTBITS-1:0] in_cnt [8];
   clu_t                 in_clu [8];
   logic [3:0]           in_valid_cnt;
   logic [1:0]           widx_nxt;
   logic [2*CluBits-1:0] first_word;
   logic [2*CluBits-1:0] next_word;

   always_comb begin
      in_adr[0] = adr0_i;  in_cnt[0] = cnt0_i;
      in_adr[1] = adr1_i;  in_cnt[1] = cnt1_i;
      in_adr[2] = adr2_i;  in_cnt[2] = cnt2_i;
      in_adr[3] = adr3_i;  in_cnt[3] = cnt3_i;
      in_adr[4] = adr4_i;  in_cnt[4] = cnt4_i;
      in_adr[5] = adr5_i;  in_cnt[5] = cnt5_i;
      in_adr[6] = adr6_i;  in_cnt[6] = cnt6_i;
      in_adr[7] = adr7_i;  in_cnt[7] = cnt7_i;
   end

   // Popcount rather than sort order, so an unsorted frame still counts correctly.
   always_comb begin
      in_valid_cnt = '0;
      for (int i = 0; i < 8; i++) begin
         in_clu[i] = {in_adr[i], in_cnt[i]};
         if ({1'b0, in_adr[i]} < ValidAdr) begin
            in_valid_cnt = in_valid_cnt + 4'd1;
         end
      end
   end

   always_comb begin
      widx_nxt   = widx_q + 2'd1;
      first_word = {in_clu[1], in_clu[0]};
      next_word  = {cap_q[{widx_nxt, 1'b1}], cap_q[{widx_nxt, 1'b0}]};
   end

   always_ff @(posedge clock4x) begin
      if (reset) begin
         state_q     <= StIdle;
         widx_q      <= 2'd0;
         for (int i = 0; i < 8; i++) begin
            cap_q[i] <= IdleClu;
         end
         dout        <= {IdleClu, IdleClu};
         dout_valid  <= 1'b0;
         dout_first  <= 1'b0;
         dout_last   <= 1'b0;
         cluster_cnt <= 4'd0;
         overrun_cnt <= 8'd0;
      end else if (frame_valid) begin
         // A strobe always wins; only one landing before the last word truncates a frame.
         if (state_q == StSend && widx_q != 2'd3 && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
         end
         for (int i = 0; i < 8; i++) begin
            cap_q[i] <= in_clu[i];
         end
         state_q     <= StSend;
         widx_q      <= 2'd0;
         dout        <= first_word;
         dout_valid  <= 1'b1;
         dout_first  <= 1'b1;
         dout_last   <= 1'b0;
         cluster_cnt <= in_valid_cnt;
      end else if (state_q == StSend) begin
         if (widx_q != 2'd3) begin
            widx_q     <= widx_nxt;
            dout       <= next_word;
            dout_valid <= 1'b1;
            dout_first <= 1'b0;
            dout_last  <= (widx_nxt == 2'd3);
         end else begin
            state_q    <= StIdle;
            dout       <= {IdleClu, IdleClu};
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cluster_word_serializer.sv
// Scoreboard bench for cluster_word_serializer: each strobe queues its four expected words,
// every cycle pops one (or expects the idle word) and compares the flags, data and counters.
module tb_cluster_word_serializer;

   localparam logic [10:0] IdleAdr = 11'h7FE;
   localparam logic [30:0] IdleExp = {3'b000, IdleAdr, 3'd0, IdleAdr, 3'd0};

   logic        clock4x = 1'b0;
   logic        reset = 1'b1;
   logic        frame_valid = 1'b0;
   logic [10:0] adr [8];
   logic [2:0]  cnt [8];
   logic [27:0] dout;
   logic        dout_valid, dout_first, dout_last;
   logic [3:0]  cluster_cnt;
   logic [7:0]  overrun_cnt;

   logic [30:0] sb [$];
   int unsigned exp_ccnt = 0;
   int unsigned exp_ovr = 0;
   int unsigned run_len = 0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   int unsigned frame1_adr [8] = '{10, 20, 30, 40, 50, 1536, 2046, 2046};

   always #5 clock4x = ~clock4x;

   cluster_word_serializer dut (
      .clock4x     (clock4x),
      .reset       (reset),
      .frame_valid (frame_valid),
      .adr0_i      (adr[0]),
      .adr1_i      (adr[1]),
      .adr2_i      (adr[2]),
      .adr3_i      (adr[3]),
      .adr4_i      (adr[4]),
      .adr5_i      (adr[5]),
      .adr6_i      (adr[6]),
      .adr7_i      (adr[7]),
      .cnt0_i      (cnt[0]),
      .cnt1_i      (cnt[1]),
      .cnt2_i      (cnt[2]),
      .cnt3_i      (cnt[3]),
      .cnt4_i      (cnt[4]),
      .cnt5_i      (cnt[5]),
      .cnt6_i      (cnt[6]),
      .cnt7_i      (cnt[7]),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_first  (dout_first),
      .dout_last   (dout_last),
      .cluster_cnt (cluster_cnt),
      .overrun_cnt (overrun_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic scramble();
      for (int i = 0; i < 8; i++) begin
         adr[i] = 11'($urandom);
         cnt[i] = 3'($urandom);
      end
   endtask

   // One clock; outputs are checked 1 time unit after the rising edge.
   task automatic sample();
      logic [30:0] e;
      @(posedge clock4x);
      #1;
      e = (sb.size() > 0) ? sb.pop_front() : IdleExp;
      run_len = dout_valid ? run_len + 1 : 0;
      check_eq("word", {1'b0, dout_valid, dout_first, dout_last, dout}, {1'b0, e});
      check_eq("cluster_cnt", {28'd0, cluster_cnt}, exp_ccnt);
      check_eq("overrun_cnt", {24'd0, overrun_cnt}, exp_ovr);
   endtask

   task automatic idle(input int n);
      repeat (n) sample();
   endtask

   // Strobe the current adr/cnt values; unsent words of an older frame are lost.
   task automatic strobe();
      int unsigned pc;
      pc = 0;
      if (sb.size() != 0) begin
         sb.delete();
         if (exp_ovr != 255) exp_ovr++;
      end
      for (int k = 0; k < 4; k++) begin
         sb.push_back({1'b1, k == 0, k == 3, adr[2*k+1], cnt[2*k+1], adr[2*k], cnt[2*k]});
      end
      for (int i = 0; i < 8; i++) if (adr[i] < 11'd1536) pc++;
      exp_ccnt = pc;
      frame_valid = 1'b1;
      sample();
      frame_valid = 1'b0;
      scramble();
   endtask

   task automatic strobe_rand();
      scramble();
      strobe();
   endtask

   task automatic do_reset(input logic with_strobe);
      scramble();
      frame_valid = with_strobe;
      reset = 1'b1;
      sb.delete();
      exp_ccnt = 0;
      exp_ovr = 0;
      sample();
      reset = 1'b0;
      frame_valid = 1'b0;
   endtask

   initial begin
      scramble();
      do_reset(1'b0);
      do_reset(1'b0);
      idle(2);

      // Single frame with mixed valid/invalid clusters.
      for (int i = 0; i < 8; i++) begin
         adr[i] = 11'(frame1_adr[i]);
         cnt[i] = 3'(i);
      end
      strobe();
      check_eq("single_ccnt", {28'd0, cluster_cnt}, 32'd5);
      sample();
      check_eq("single_w1", {4'd0, dout}, {4'd0, 11'd40, 3'd3, 11'd30, 3'd2});
      idle(2);
      check_eq("single_last", {31'd0, dout_last}, 32'd1);
      sample();
      check_eq("single_idle", {31'd0, dout_valid}, 32'd0);
      idle(2);

      // Back-to-back frames every 4 cycles.
      for (int f = 0; f < 3; f++) begin
         strobe_rand();
         idle(3);
      end
      check_eq("b2b_run", run_len, 32'd12);
      check_eq("b2b_ovr", {24'd0, overrun_cnt}, 32'd0);
      idle(2);

      // Overrun: second strobe two cycles after the first.
      strobe_rand();
      idle(1);
      strobe_rand();
      idle(3);
      check_eq("ovr_one", {24'd0, overrun_cnt}, 32'd1);
      idle(2);

      // Empty then full frame.
      for (int i = 0; i < 8; i++) adr[i] = 11'd2046;
      strobe();
      check_eq("empty_ccnt", {28'd0, cluster_cnt}, 32'd0);
      idle(3);
      for (int i = 0; i < 8; i++) adr[i] = 11'(i);
      strobe();
      check_eq("full_ccnt", {28'd0, cluster_cnt}, 32'd8);
      idle(5);

      // Saturation: strobes on consecutive cycles.
      repeat (300) strobe_rand();
      check_eq("sat_255", {24'd0, overrun_cnt}, 32'd255);
      repeat (5) strobe_rand();
      check_eq("sat_hold", {24'd0, overrun_cnt}, 32'd255);
      idle(5);

      // Reset after word 1, then reset coinciding with a strobe.
      strobe_rand();
      idle(1);
      do_reset(1'b0);
      check_eq("rst_valid", {31'd0, dout_valid}, 32'd0);
      check_eq("rst_ovr", {24'd0, overrun_cnt}, 32'd0);
      idle(5);
      strobe_rand();
      do_reset(1'b1);
      check_eq("rst_strobe_valid", {31'd0, dout_valid}, 32'd0);
      check_eq("rst_strobe_ccnt", {28'd0, cluster_cnt}, 32'd0);
      idle(5);

      // Recovery after reset.
      strobe_rand();
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
